// File: rtl/invader_fire_ctrl_pkg.sv
// Shared constants and state encoding for the invader fire scheduler.
package invader_fire_ctrl_pkg;

    localparam int INVADERS_H = 11;
    localparam int INVADERS_V = 5;
    localparam int NUM_SLOTS  = 3;

    // Galois feedback mask for x^16 + x^14 + x^13 + x^11 (right-shifting form).
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PICK  = 3'd1,
        ST_SCAN  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_COOL  = 3'd4
    } state_t;

endpackage

// File: rtl/invader_fire_ctrl_lfsr.sv
// Free-running 16-bit Galois LFSR; exposes the low nibble used for column choice.
module fire_lfsr
    import invader_fire_ctrl_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] lfsr_col_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Next LFSR value: shift right, fold taps back in when the outgoing bit is set.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end

    // LFSR state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_col_o = lfsr_q[3:0];

endmodule

// File: rtl/invader_fire_ctrl.sv
// Invader shot scheduler: cooldown pacing, random column pick, bottom-most
// alive invader search and valid/ack hand-off to the missile datapath.
module invader_fire_ctrl
    import invader_fire_ctrl_pkg::*;
#(
    parameter int          COOLDOWN_FRAMES = 48,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame,
    input  logic        enable,
    input  logic [54:0] alive,
    input  logic [2:0]  slot_busy,
    output logic        fire_valid,
    input  logic        fire_ack,
    output logic [1:0]  fire_slot,
    output logic [3:0]  fire_col,
    output logic [2:0]  fire_row,
    output logic [5:0]  fire_num
);

    state_t      state_q, state_d;
    logic [7:0]  cool_q, cool_d;
    logic [3:0]  scan_col_q, scan_col_d;
    logic [3:0]  scan_cnt_q, scan_cnt_d;
    logic        valid_q, valid_d;
    logic [1:0]  slot_q, slot_d;
    logic [3:0]  col_q, col_d;
    logic [2:0]  row_q, row_d;
    logic [5:0]  num_q, num_d;

    logic [3:0]  lfsr_col_s;
    logic [3:0]  pick_col_s;
    logic [1:0]  free_slot_s;
    logic [4:0]  col_bits_s;
    logic        hit_s;
    logic [2:0]  hit_row_s;
    logic [5:0]  num_s;

    fire_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk        (clk),
        .rst        (rst),
        .lfsr_col_o (lfsr_col_s)
    );

    // Column choice, free-slot and bottom-most-row priority encoders.
    always_comb begin
        pick_col_s = (lfsr_col_s >= 4'd11) ? (lfsr_col_s - 4'd11) : lfsr_col_s;
        casez (slot_busy)
            3'b??0:  free_slot_s = 2'd0;
            3'b?01:  free_slot_s = 2'd1;
            3'b011:  free_slot_s = 2'd2;
            default: free_slot_s = 2'd0;
        endcase
        col_bits_s = 5'b00000;
        for (int r = 0; r < INVADERS_V; r++) begin
            col_bits_s[r] = alive[6'(r * INVADERS_H) + 6'(scan_col_q)];
        end
        hit_s = |col_bits_s;
        casez (col_bits_s)
            5'b1????: hit_row_s = 3'd4;
            5'b01???: hit_row_s = 3'd3;
            5'b001??: hit_row_s = 3'd2;
            5'b0001?: hit_row_s = 3'd1;
            5'b00001: hit_row_s = 3'd0;
            default:  hit_row_s = 3'd0;
        endcase
        num_s = 6'(hit_row_s) * 6'd11 + 6'(scan_col_q);
    end

    // Scheduler next-state logic; enable low forces a return to idle.
    always_comb begin
        state_d    = state_q;
        cool_d     = cool_q;
        scan_col_d = scan_col_q;
        scan_cnt_d = scan_cnt_q;
        valid_d    = valid_q;
        slot_d     = slot_q;
        col_d      = col_q;
        row_d      = row_q;
        num_d      = num_q;
        case (state_q)
            ST_IDLE: begin
                if (frame && (slot_busy != 3'b111)) begin
                    state_d = ST_PICK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PICK: begin
                slot_d     = free_slot_s;
                scan_col_d = pick_col_s;
                scan_cnt_d = 4'd0;
                state_d    = ST_SCAN;
            end
            ST_SCAN: begin
                if (hit_s) begin
                    col_d   = scan_col_q;
                    row_d   = hit_row_s;
                    num_d   = num_s;
                    valid_d = 1'b1;
                    state_d = ST_ISSUE;
                end else begin
                    scan_col_d = (scan_col_q == 4'd10) ? 4'd0 : (scan_col_q + 4'd1);
                    scan_cnt_d = scan_cnt_q + 4'd1;
                    // Eleventh consecutive miss means the formation is empty.
                    state_d    = (scan_cnt_q == 4'd10) ? ST_IDLE : ST_SCAN;
                end
            end
            ST_ISSUE: begin
                if (fire_ack) begin
                    valid_d = 1'b0;
                    cool_d  = 8'(COOLDOWN_FRAMES);
                    state_d = ST_COOL;
                end else begin
                    valid_d = 1'b1;
                end
            end
            ST_COOL: begin
                if (frame) begin
                    cool_d  = (cool_q <= 8'd1) ? 8'd0 : (cool_q - 8'd1);
                    state_d = (cool_q <= 8'd1) ? ST_IDLE : ST_COOL;
                end else begin
                    state_d = ST_COOL;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
        if (!enable) begin
            valid_d = 1'b0;
            state_d = ST_IDLE;
        end else begin
            valid_d = valid_d;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cool_q     <= 8'd0;
            scan_col_q <= 4'd0;
            scan_cnt_q <= 4'd0;
            valid_q    <= 1'b0;
            slot_q     <= 2'd0;
            col_q      <= 4'd0;
            row_q      <= 3'd0;
            num_q      <= 6'd0;
        end else begin
            state_q    <= state_d;
            cool_q     <= cool_d;
            scan_col_q <= scan_col_d;
            scan_cnt_q <= scan_cnt_d;
            valid_q    <= valid_d;
            slot_q     <= slot_d;
            col_q      <= col_d;
            row_q      <= row_d;
            num_q      <= num_d;
        end
    end

    assign fire_valid = valid_q;
    assign fire_slot  = slot_q;
    assign fire_col   = col_q;
    assign fire_row   = row_q;
    assign fire_num   = num_q;

endmodule

// File: tb/tb_invader_fire_ctrl.sv
// Directed bench for invader_fire_ctrl with hand-computed expectations.
module tb_invader_fire_ctrl;
    import invader_fire_ctrl_pkg::*;

    localparam int COOL_FR = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame;
    logic        enable;
    logic [54:0] alive;
    logic [2:0]  slot_busy;
    logic        fire_valid;
    logic        fire_ack;
    logic [1:0]  fire_slot;
    logic [3:0]  fire_col;
    logic [2:0]  fire_row;
    logic [5:0]  fire_num;

    int n_checks = 0;
    int n_fail   = 0;

    invader_fire_ctrl #(.COOLDOWN_FRAMES(COOL_FR), .LFSR_SEED(16'hACE1)) dut (
        .clk        (clk),
        .rst        (rst),
        .frame      (frame),
        .enable     (enable),
        .alive      (alive),
        .slot_busy  (slot_busy),
        .fire_valid (fire_valid),
        .fire_ack   (fire_ack),
        .fire_slot  (fire_slot),
        .fire_col   (fire_col),
        .fire_row   (fire_row),
        .fire_num   (fire_num)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_frame();
        frame = 1'b1;
        @(negedge clk);
        frame = 1'b0;
    endtask

    // Samples once per cycle for up to 13 cycles after the frame edge.
    task automatic wait_valid(input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 13 && !got; i++) begin
            if (fire_valid) got = 1'b1;
            else if (i < 12) @(negedge clk);
        end
        check_eq(tag, 32'(got), 32'd1);
    endtask

    task automatic check_shot(input string tag, input int slot, input int col, input int row, input int num);
        check_eq({tag, "_slot"}, 32'(fire_slot), 32'(slot));
        check_eq({tag, "_col"},  32'(fire_col),  32'(col));
        check_eq({tag, "_row"},  32'(fire_row),  32'(row));
        check_eq({tag, "_num"},  32'(fire_num),  32'(num));
    endtask

    task automatic ack_shot(input string tag);
        fire_ack = 1'b1;
        @(negedge clk);
        fire_ack = 1'b0;
        check_eq({tag, "_ack_drop"}, 32'(fire_valid), 32'd0);
    endtask

    task automatic expect_quiet(input string tag, input int n);
        bit seen = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (fire_valid) seen = 1'b1;
        end
        check_eq(tag, 32'(seen), 32'd0);
    endtask

    task automatic cool_down();
        pulse_frame();
        step(2);
        pulse_frame();
        step(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst = 1'b1; frame = 1'b0; enable = 1'b1; fire_ack = 1'b0;
        alive = '1; slot_busy = 3'b000;
        step(2);
        check_eq("rst_valid", 32'(fire_valid), 32'd0);
        check_eq("rst_outs", 32'({fire_slot, fire_col, fire_row, fire_num}), 32'd0);
        check_eq("rst_lfsr", 32'(dut.u_lfsr.lfsr_q), 32'hACE1);
        check_eq("rst_state", 32'(dut.state_q), 32'(ST_IDLE));

        // LFSR sequence ACE1 -> E270 -> 7138 -> 389C; 0xC folds to column 1.
        rst = 1'b0;
        @(negedge clk);
        check_eq("lfsr_step1", 32'(dut.u_lfsr.lfsr_q), 32'hE270);
        @(negedge clk);
        check_eq("lfsr_step2", 32'(dut.u_lfsr.lfsr_q), 32'h7138);
        pulse_frame();
        wait_valid("full_valid");
        check_shot("full", 0, 1, 4, 45);
        ack_shot("full");
        check_eq("hold_col", 32'(fire_col), 32'd1);
        cool_down();

        // Single invader, then cooldown pacing over three frames.
        alive = '0; alive[47] = 1'b1;
        pulse_frame();
        wait_valid("single_valid");
        check_shot("single", 0, 3, 4, 47);
        step(3);
        check_eq("single_hold", 32'(fire_valid), 32'd1);
        ack_shot("single");
        pulse_frame();
        expect_quiet("cool_f1", 15);
        pulse_frame();
        expect_quiet("cool_f2", 15);
        pulse_frame();
        wait_valid("cool_f3_valid");
        ack_shot("cool_f3");
        cool_down();

        // Bottom-most alive invader wins; request frozen against input changes.
        alive = '0; alive[3] = 1'b1; alive[25] = 1'b1; alive[36] = 1'b1;
        slot_busy = 3'b001;
        pulse_frame();
        wait_valid("bottom_valid");
        check_shot("bottom", 1, 3, 3, 36);
        alive = '0; slot_busy = 3'b111;
        step(2);
        check_shot("frozen", 1, 3, 3, 36);
        check_eq("frozen_valid", 32'(fire_valid), 32'd1);
        ack_shot("bottom");
        cool_down();

        // All slots busy: frames do not start a shot.
        alive[3] = 1'b1; alive[25] = 1'b1; alive[36] = 1'b1;
        for (int f = 0; f < 3; f++) begin
            pulse_frame();
            expect_quiet("sat_quiet", 15);
        end
        slot_busy = 3'b110;
        pulse_frame();
        wait_valid("sat_valid");
        check_shot("sat", 0, 3, 3, 36);
        ack_shot("sat");
        cool_down();

        // Empty formation: 11 misses then back to idle.
        alive = '0; slot_busy = 3'b000;
        pulse_frame();
        seen = 1'b0;
        repeat (11) begin
            @(negedge clk);
            if (fire_valid) seen = 1'b1;
        end
        check_eq("empty_scanning", 32'(dut.state_q), 32'(ST_SCAN));
        @(negedge clk);
        check_eq("empty_idle", 32'(dut.state_q), 32'(ST_IDLE));
        check_eq("empty_no_valid", 32'(seen), 32'd0);

        // Abort by enable, stray ack, then reset during issue.
        alive[47] = 1'b1;
        pulse_frame();
        wait_valid("abort_valid");
        enable = 1'b0;
        @(negedge clk);
        check_eq("abort_drop", 32'(fire_valid), 32'd0);
        check_eq("abort_idle", 32'(dut.state_q), 32'(ST_IDLE));
        enable = 1'b1;
        fire_ack = 1'b1;
        @(negedge clk);
        fire_ack = 1'b0;
        check_eq("stray_ack", 32'(dut.state_q), 32'(ST_IDLE));
        pulse_frame();
        wait_valid("rst_issue_valid");
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst2_valid", 32'(fire_valid), 32'd0);
        check_eq("rst2_outs", 32'({fire_slot, fire_col, fire_row, fire_num}), 32'd0);
        check_eq("rst2_lfsr", 32'(dut.u_lfsr.lfsr_q), 32'hACE1);
        rst = 1'b0;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
